// File: rtl/screen_sequencer.sv
// Game screen sequencer: title/idle/countdown/play/pause/win states with a
// full-frame 160x120 redraw sweep on each screen change. Pause via SCREEN_SEQ_PAUSE_EN.
module screen_sequencer #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned COUNT_FROM    = 5
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       pause_req,
  input  logic       game_over,
  input  logic       winner,
  output logic [5:0] screen_en,
  output logic [2:0] count_value,
  output logic       play_active,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       plot,
  output logic       redraw_busy
);

  localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [7:0]  X_LAST = 8'd159;
  localparam logic [6:0]  Y_LAST = 7'd119;

  typedef enum logic [2:0] {
    S_TITLE, S_IDLE, S_COUNTDOWN, S_PLAY, S_PAUSE, S_A_WON, S_B_WON
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          count_q, count_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [5:0]          screen_en_q, screen_en_d;
  logic                play_active_q, play_active_d;
  logic [7:0]          x_q, x_d;
  logic [6:0]          y_q, y_d;
  logic                busy_q, busy_d;
  logic                sweep_req_q, sweep_req_d;

  logic                gate_c;
  logic                start_ok_c;
  logic                over_ok_c;

  // A pending or running sweep blocks user input; pulses are dropped, not queued.
  assign gate_c     = busy_q | sweep_req_q;
  assign start_ok_c = start & ~gate_c;
  assign over_ok_c  = game_over & ~gate_c;

`ifdef SCREEN_SEQ_PAUSE_EN
  logic pause_ok_c;
  assign pause_ok_c = pause_req & ~gate_c;
`else
  logic unused_pause_req;
  assign unused_pause_req = pause_req;
`endif

  // Next-state, countdown and redraw sweep logic
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    tick_d      = '0;
    sweep_req_d = 1'b0;
    x_d         = 8'd0;
    y_d         = 7'd0;
    busy_d      = 1'b0;
    screen_en_d = 6'b000000;

    case (state_q)
      S_TITLE: if (start_ok_c) state_d = S_IDLE;
      S_IDLE: begin
        if (start_ok_c) begin
          state_d = S_COUNTDOWN;
          count_d = 3'(COUNT_FROM);
        end
      end
      S_COUNTDOWN: begin
        if (tick_q == TICK_W'(TICKS_PER_SEC - 1)) begin
          if (count_q == 3'd1) begin
            count_d = 3'd0;
            state_d = S_PLAY;
          end else begin
            count_d = count_q - 3'd1;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_PLAY: begin
        if (over_ok_c) begin
          state_d = winner ? S_B_WON : S_A_WON;
        end
`ifdef SCREEN_SEQ_PAUSE_EN
        else if (pause_ok_c) begin
          state_d = S_PAUSE;
        end
`endif
      end
`ifdef SCREEN_SEQ_PAUSE_EN
      S_PAUSE: if (pause_ok_c) state_d = S_PLAY;
`endif
      S_A_WON, S_B_WON: if (start_ok_c) state_d = S_TITLE;
      default: state_d = S_TITLE;
    endcase

    if (state_d != state_q && state_d != S_PLAY) begin
      sweep_req_d = 1'b1;
    end else if (state_q == S_COUNTDOWN && state_d == S_COUNTDOWN && count_d != count_q) begin
      sweep_req_d = 1'b1;
    end

    // Row-major sweep; a fresh request always restarts at the origin
    if (sweep_req_q) begin
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (x_q == X_LAST && y_q == Y_LAST) begin
        busy_d = 1'b0;
      end else if (x_q == X_LAST) begin
        busy_d = 1'b1;
        y_d    = y_q + 7'd1;
      end else begin
        busy_d = 1'b1;
        x_d    = x_q + 8'd1;
        y_d    = y_q;
      end
    end

    case (state_d)
      S_TITLE:     screen_en_d = 6'b000001;
      S_IDLE:      screen_en_d = 6'b000010;
      S_PAUSE:     screen_en_d = 6'b000100;
      S_COUNTDOWN: screen_en_d = 6'b001000;
      S_A_WON:     screen_en_d = 6'b010000;
      S_B_WON:     screen_en_d = 6'b100000;
      default:     screen_en_d = 6'b000000;
    endcase
    play_active_d = (state_d == S_PLAY);
  end

  // Title state is entered with a sweep pending so it starts right after reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= S_TITLE;
      count_q       <= 3'd0;
      tick_q        <= '0;
      screen_en_q   <= 6'b000001;
      play_active_q <= 1'b0;
      x_q           <= 8'd0;
      y_q           <= 7'd0;
      busy_q        <= 1'b0;
      sweep_req_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      tick_q        <= tick_d;
      screen_en_q   <= screen_en_d;
      play_active_q <= play_active_d;
      x_q           <= x_d;
      y_q           <= y_d;
      busy_q        <= busy_d;
      sweep_req_q   <= sweep_req_d;
    end
  end

  assign screen_en   = screen_en_q;
  assign count_value = count_q;
  assign play_active = play_active_q;
  assign x           = x_q;
  assign y           = y_q;
  assign plot        = busy_q;
  assign redraw_busy = busy_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer (TICKS_PER_SEC=20000, COUNT_FROM=3).
// Pause expectations follow SCREEN_SEQ_PAUSE_EN.
module tb_screen_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       pause_req;
  logic       game_over;
  logic       winner;
  logic [5:0] screen_en;
  logic [2:0] count_value;
  logic       play_active;
  logic [7:0] x;
  logic [6:0] y;
  logic       plot;
  logic       redraw_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  screen_sequencer #(
    .TICKS_PER_SEC(20000),
    .COUNT_FROM   (3)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .start      (start),
    .pause_req  (pause_req),
    .game_over  (game_over),
    .winner     (winner),
    .screen_en  (screen_en),
    .count_value(count_value),
    .play_active(play_active),
    .x          (x),
    .y          (y),
    .plot       (plot),
    .redraw_busy(redraw_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_req = 1'b1;
    @(negedge clk);
    pause_req = 1'b0;
  endtask

  // Bounded wait for the running/pending sweep to finish
  task automatic wait_sweep_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (redraw_busy === 1'b1 && n < 20000);
    tests_run++;
    if (redraw_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_sweep_timeout: busy=%b after %0d cycles, want 0", name, redraw_busy, n);
    end
  endtask

  task automatic test_reset();
    int n;
    logic [7:0] lx;
    logic [6:0] ly;
    reset = 1'b1; start = 1'b0; pause_req = 1'b0; game_over = 1'b0; winner = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (screen_en !== 6'b000001) begin tests_failed++; $display("FAIL reset_screen_en: got %b want 000001", screen_en); end
    tests_run++;
    if (count_value !== 3'd0 || play_active !== 1'b0) begin tests_failed++; $display("FAIL reset_count_play: got count=%0d play=%b want 0/0", count_value, play_active); end
    tests_run++;
    if (x !== 8'd0 || y !== 7'd0 || plot !== 1'b0 || redraw_busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_sweep: got x=%0d y=%0d plot=%b busy=%b want 0/0/0/0", x, y, plot, redraw_busy);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (plot !== 1'b1 || x !== 8'd0 || y !== 7'd0) begin tests_failed++; $display("FAIL title_sweep_start: got plot=%b x=%0d y=%0d want 1/0/0", plot, x, y); end
    n = 0; lx = 8'd0; ly = 7'd0;
    while (plot === 1'b1 && n < 20000) begin
      lx = x; ly = y; n++;
      @(negedge clk);
    end
    tests_run++;
    if (n != 19200) begin tests_failed++; $display("FAIL title_plot_len: got %0d want 19200", n); end
    tests_run++;
    if (lx !== 8'd159 || ly !== 7'd119) begin tests_failed++; $display("FAIL title_last_pixel: got (%0d,%0d) want (159,119)", lx, ly); end
    tests_run++;
    if (redraw_busy !== 1'b0 || x !== 8'd0 || y !== 7'd0) begin tests_failed++; $display("FAIL title_sweep_idle: got busy=%b x=%0d y=%0d want 0/0/0", redraw_busy, x, y); end
  endtask

  task automatic test_drop_during_sweep();
    pulse_start();
    tests_run++;
    if (screen_en !== 6'b000010) begin tests_failed++; $display("FAIL title_to_idle: got %b want 000010", screen_en); end
    repeat (5001) @(negedge clk);
    tests_run++;
    if (x !== 8'd40 || y !== 7'd31 || plot !== 1'b1) begin tests_failed++; $display("FAIL idle_pixel_5000: got (%0d,%0d) plot=%b want (40,31) 1", x, y, plot); end
    pulse_start();
    tests_run++;
    if (screen_en !== 6'b000010 || x !== 8'd41 || y !== 7'd31) begin
      tests_failed++; $display("FAIL idle_start_dropped: got en=%b (%0d,%0d) want 000010 (41,31)", screen_en, x, y);
    end
    wait_sweep_done("idle");
    tests_run++;
    if (screen_en !== 6'b000010) begin tests_failed++; $display("FAIL idle_start_not_queued: got %b want 000010", screen_en); end
    pulse_start();
    tests_run++;
    if (screen_en !== 6'b001000 || count_value !== 3'd3) begin tests_failed++; $display("FAIL idle_to_countdown: got en=%b count=%0d want 001000/3", screen_en, count_value); end
  endtask

  task automatic test_countdown();
    repeat (19999) @(negedge clk);
    tests_run++;
    if (count_value !== 3'd3) begin tests_failed++; $display("FAIL count3_hold: got %0d want 3", count_value); end
    @(negedge clk);
    tests_run++;
    if (count_value !== 3'd2) begin tests_failed++; $display("FAIL count3_to_2: got %0d want 2", count_value); end
    repeat (19999) @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (count_value !== 3'd1 || screen_en !== 6'b001000) begin tests_failed++; $display("FAIL count2_to_1: got count=%0d en=%b want 1/001000", count_value, screen_en); end
    repeat (19999) @(negedge clk);
    tests_run++;
    if (play_active !== 1'b0) begin tests_failed++; $display("FAIL play_early: got play=%b want 0", play_active); end
    @(negedge clk);
    tests_run++;
    if (play_active !== 1'b1 || screen_en !== 6'b000000 || count_value !== 3'd0) begin
      tests_failed++; $display("FAIL enter_play: got play=%b en=%b count=%0d want 1/000000/0", play_active, screen_en, count_value);
    end
    @(negedge clk);
    tests_run++;
    if (plot !== 1'b0) begin tests_failed++; $display("FAIL play_no_sweep: got plot=%b want 0", plot); end
  endtask

  task automatic test_pause();
    pulse_pause();
`ifdef SCREEN_SEQ_PAUSE_EN
    tests_run++;
    if (screen_en !== 6'b000100 || play_active !== 1'b0) begin tests_failed++; $display("FAIL enter_pause: got en=%b play=%b want 000100/0", screen_en, play_active); end
    @(negedge clk);
    tests_run++;
    if (plot !== 1'b1) begin tests_failed++; $display("FAIL pause_sweep: got plot=%b want 1", plot); end
    wait_sweep_done("pause");
    pulse_pause();
    tests_run++;
    if (screen_en !== 6'b000000 || play_active !== 1'b1 || count_value !== 3'd0) begin
      tests_failed++; $display("FAIL resume_play: got en=%b play=%b count=%0d want 000000/1/0", screen_en, play_active, count_value);
    end
`else
    tests_run++;
    if (screen_en !== 6'b000000 || play_active !== 1'b1) begin tests_failed++; $display("FAIL pause_ignored: got en=%b play=%b want 000000/1", screen_en, play_active); end
`endif
    @(negedge clk);
    tests_run++;
    if (plot !== 1'b0) begin tests_failed++; $display("FAIL play_after_pause_no_sweep: got plot=%b want 0", plot); end
  endtask

  task automatic test_game_over_priority();
    game_over = 1'b1; winner = 1'b1; pause_req = 1'b1;
    @(negedge clk);
    game_over = 1'b0; winner = 1'b0; pause_req = 1'b0;
    tests_run++;
    if (screen_en !== 6'b100000 || play_active !== 1'b0) begin tests_failed++; $display("FAIL b_won_over_pause: got en=%b play=%b want 100000/0", screen_en, play_active); end
    wait_sweep_done("b_won");
    tests_run++;
    if (screen_en !== 6'b100000) begin tests_failed++; $display("FAIL b_won_latched: got %b want 100000", screen_en); end
    pulse_start();
    tests_run++;
    if (screen_en !== 6'b000001) begin tests_failed++; $display("FAIL b_won_to_title: got %b want 000001", screen_en); end
  endtask

  task automatic test_reset_mid_countdown();
    wait_sweep_done("title2");
    pulse_start();
    wait_sweep_done("idle2");
    pulse_start();
    tests_run++;
    if (screen_en !== 6'b001000) begin tests_failed++; $display("FAIL countdown2_entry: got %b want 001000", screen_en); end
    repeat (20100) @(negedge clk);
    tests_run++;
    if (count_value !== 3'd2 || plot !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_state: got count=%0d plot=%b want 2/1", count_value, plot); end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (screen_en !== 6'b000001 || count_value !== 3'd0) begin tests_failed++; $display("FAIL midreset_state: got en=%b count=%0d want 000001/0", screen_en, count_value); end
    tests_run++;
    if (x !== 8'd0 || y !== 7'd0 || plot !== 1'b0 || redraw_busy !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_sweep: got x=%0d y=%0d plot=%b busy=%b want 0/0/0/0", x, y, plot, redraw_busy);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (plot !== 1'b1 || x !== 8'd0 || screen_en !== 6'b000001) begin tests_failed++; $display("FAIL title_after_midreset: got plot=%b x=%0d en=%b want 1/0/000001", plot, x, screen_en); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause_req = 1'b0; game_over = 1'b0; winner = 1'b0;
    @(negedge clk);
    test_reset();
    test_drop_during_sweep();
    test_countdown();
    test_pause();
    test_game_over_priority();
    test_reset_mid_countdown();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
